lvt_bank_table: RTL and testbench

LVT_BANK_TABLE -- requirements
Module: lvt_bank_table

---
 rtl/lvt_bank_table.sv | 116 +++++++++++
 tb/tb_lvt_bank_table.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_bank_table.sv
`default_nettype none
// lvt_bank_table: live value table recording which write port last wrote each entry.
// Cleared by an INIT sweep after reset or clr; reads have one-cycle latency and are read-first.
module lvt_bank_table #(
  parameter int INDEX_WIDTH = 8,
  parameter int N_WR        = 2,
  parameter int N_RD        = 2,
  parameter int BANK_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic [N_WR-1:0]             w_en,
  input  logic [N_WR*INDEX_WIDTH-1:0] w_addr,
  input  logic [N_RD-1:0]             r_en,
  input  logic [N_RD*INDEX_WIDTH-1:0] r_addr,
  output logic [N_RD*BANK_BITS-1:0]   r_bank,
  output logic [N_RD-1:0]             r_valid,
  output logic                        ready,
  output logic                        w_conflict
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [BANK_BITS-1:0]      r_table [DEPTH];
  logic [0:0]                r_state;
  logic [INDEX_WIDTH-1:0]    r_sweep;
  logic [N_RD*BANK_BITS-1:0] r_bank_q;
  logic [N_RD-1:0]           r_valid_q;
  logic                      r_conflict;

  logic w_active;
  logic w_collide;

  // Ports only act in READY and only when no clear is requested this cycle.
  assign w_active = (r_state == S_READY) && !clr;

  always_comb begin
    w_collide = 1'b0;
    for (int i = 0; i < N_WR; i++) begin
      for (int k = i + 1; k < N_WR; k++) begin
        if (w_en[i] && w_en[k] &&
            (w_addr[i*INDEX_WIDTH +: INDEX_WIDTH] == w_addr[k*INDEX_WIDTH +: INDEX_WIDTH])) begin
          w_collide = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_INIT;
      r_sweep    <= '0;
      r_bank_q   <= '0;
      r_valid_q  <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_active && w_collide;
      case (r_state)
        S_INIT: begin
          r_valid_q <= '0;
          if (clr) begin
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + INDEX_WIDTH'(1);
            if (&r_sweep) begin
              r_state <= S_READY;
            end
          end
        end
        default: begin
          if (clr) begin
            r_state   <= S_INIT;
            r_sweep   <= '0;
            r_valid_q <= '0;
          end else begin
            for (int j = 0; j < N_RD; j++) begin
              if (r_en[j]) begin
                r_bank_q[j*BANK_BITS +: BANK_BITS] <= r_table[r_addr[j*INDEX_WIDTH +: INDEX_WIDTH]];
                r_valid_q[j] <= 1'b1;
              end else begin
                r_valid_q[j] <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // Table is not reset; later loop iterations win, so the highest port index is stored on collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == S_INIT) begin
        if (!clr) begin
          r_table[r_sweep] <= '0;
        end
      end else if (!clr) begin
        for (int i = 0; i < N_WR; i++) begin
          if (w_en[i]) begin
            r_table[w_addr[i*INDEX_WIDTH +: INDEX_WIDTH]] <= BANK_BITS'(i);
          end
        end
      end
    end
  end

  assign r_bank     = r_bank_q;
  assign r_valid    = r_valid_q;
  assign ready      = (r_state == S_READY);
  assign w_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_lvt_bank_table.sv
`default_nettype none
// tb_lvt_bank_table: directed self-checking bench for lvt_bank_table at default parameters.
module tb_lvt_bank_table;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  w_en = '0;
  logic [15:0] w_addr = '0;
  logic [1:0]  r_en = '0;
  logic [15:0] r_addr = '0;
  logic [1:0]  r_bank;
  logic [1:0]  r_valid;
  logic        ready;
  logic        w_conflict;

  int checks = 0;
  int errors = 0;

  lvt_bank_table #(
    .INDEX_WIDTH(8),
    .N_WR(2),
    .N_RD(2),
    .BANK_BITS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .w_en(w_en),
    .w_addr(w_addr),
    .r_en(r_en),
    .r_addr(r_addr),
    .r_bank(r_bank),
    .r_valid(r_valid),
    .ready(ready),
    .w_conflict(w_conflict)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] en);
    r_addr = {a1, a0};
    r_en   = en;
    step();
    r_en   = 2'b00;
  endtask

  task automatic do_write(input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] en);
    w_addr = {a1, a0};
    w_en   = en;
    step();
    w_en   = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (r_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", r_valid); end
    checks++;
    if (r_bank !== 2'b00) begin errors++; $display("FAIL reset_bank: got %b expected 00", r_bank); end
    checks++;
    if (w_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", w_conflict); end
  endtask

  task automatic test_init();
    // Port activity during the sweep must be ignored.
    w_en   = 2'b11;
    w_addr = {8'h33, 8'h33};
    r_en   = 2'b11;
    r_addr = {8'h33, 8'h34};
    reset  = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      step();
      checks++;
      if (ready !== (n == 256)) begin
        errors++;
        $display("FAIL init_ready edge %0d: got %b expected %b", n, ready, (n == 256));
      end
      checks++;
      if (r_valid !== 2'b00 || w_conflict !== 1'b0) begin
        errors++;
        $display("FAIL init_quiet edge %0d: got valid=%b conflict=%b expected 00/0", n, r_valid, w_conflict);
      end
    end
    w_en = 2'b00;
    r_en = 2'b00;
    for (int a = 0; a < 128; a++) begin
      do_read(8'(2*a), 8'(2*a+1), 2'b11);
      checks++;
      if (r_valid !== 2'b11 || r_bank !== 2'b00) begin
        errors++;
        $display("FAIL init_contents addr %0d: got valid=%b bank=%b expected 11/00", 2*a, r_valid, r_bank);
      end
    end
  endtask

  task automatic test_single_write();
    do_write(8'h00, 8'h3C, 2'b10);
    do_read(8'h3C, 8'h00, 2'b01);
    checks++;
    if (r_valid !== 2'b01) begin errors++; $display("FAIL single_valid: got %b expected 01", r_valid); end
    checks++;
    if (r_bank[0] !== 1'b1) begin errors++; $display("FAIL single_bank: got %b expected 1", r_bank[0]); end
  endtask

  task automatic test_hold();
    step();
    checks++;
    if (r_valid !== 2'b00) begin errors++; $display("FAIL hold_valid: got %b expected 00", r_valid); end
    checks++;
    if (r_bank[0] !== 1'b1) begin errors++; $display("FAIL hold_bank: got %b expected 1", r_bank[0]); end
  endtask

  task automatic test_collision();
    do_write(8'h10, 8'h10, 2'b11);
    checks++;
    if (w_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b expected 1", w_conflict); end
    step();
    checks++;
    if (w_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clear: got %b expected 0", w_conflict); end
    do_read(8'h10, 8'h10, 2'b11);
    checks++;
    if (r_valid !== 2'b11 || r_bank !== 2'b11) begin
      errors++;
      $display("FAIL conflict_winner: got valid=%b bank=%b expected 11/11", r_valid, r_bank);
    end
    do_write(8'h40, 8'h41, 2'b11);
    checks++;
    if (w_conflict !== 1'b0) begin errors++; $display("FAIL no_conflict: got %b expected 0", w_conflict); end
    do_read(8'h40, 8'h41, 2'b11);
    checks++;
    if (r_bank !== 2'b10) begin errors++; $display("FAIL dual_write: got %b expected 10", r_bank); end
  endtask

  task automatic test_read_first();
    do_write(8'h00, 8'h20, 2'b10);
    w_addr = {8'h00, 8'h20};
    w_en   = 2'b01;
    r_addr = {8'h20, 8'h00};
    r_en   = 2'b10;
    step();
    w_en = 2'b00;
    r_en = 2'b00;
    checks++;
    if (r_valid !== 2'b10 || r_bank[1] !== 1'b1) begin
      errors++;
      $display("FAIL read_first_old: got valid=%b bank1=%b expected 10/1", r_valid, r_bank[1]);
    end
    do_read(8'h00, 8'h20, 2'b10);
    checks++;
    if (r_bank[1] !== 1'b0) begin errors++; $display("FAIL read_first_new: got %b expected 0", r_bank[1]); end
  endtask

  task automatic test_clr();
    do_write(8'h00, 8'h05, 2'b10);
    clr    = 1'b1;
    w_addr = {8'h05, 8'h05};
    w_en   = 2'b10;
    r_addr = {8'h00, 8'h05};
    r_en   = 2'b01;
    step();
    clr  = 1'b0;
    w_en = 2'b00;
    r_en = 2'b00;
    checks++;
    if (ready !== 1'b0 || r_valid !== 2'b00) begin
      errors++;
      $display("FAIL clr_enter: got ready=%b valid=%b expected 0/00", ready, r_valid);
    end
    for (int n = 2; n <= 257; n++) begin
      step();
      checks++;
      if (ready !== (n == 257)) begin
        errors++;
        $display("FAIL clr_ready edge %0d: got %b expected %b", n, ready, (n == 257));
      end
    end
    do_read(8'h05, 8'h3C, 2'b11);
    checks++;
    if (r_valid !== 2'b11 || r_bank !== 2'b00) begin
      errors++;
      $display("FAIL clr_contents: got valid=%b bank=%b expected 11/00", r_valid, r_bank);
    end
  endtask

  task automatic test_clr_in_init();
    int edges;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (50) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    edges = 0;
    while (ready !== 1'b1 && edges < 400) begin
      step();
      edges++;
    end
    checks++;
    if (edges != 256) begin errors++; $display("FAIL clr_in_init_edges: got %0d expected 256", edges); end
  endtask

  task automatic test_midsweep_reset();
    int edges;
    do_read(8'h01, 8'h02, 2'b11);
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || r_valid !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b expected 0/00", ready, r_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (100) step();
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL midsweep_reset_ready: got %b expected 0", ready); end
    @(negedge clk);
    step();
    reset = 1'b1;
    edges = 0;
    while (ready !== 1'b1 && edges < 400) begin
      step();
      edges++;
    end
    checks++;
    if (edges != 256) begin errors++; $display("FAIL midsweep_edges: got %0d expected 256", edges); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_hold();
    test_collision();
    test_read_first();
    test_clr();
    test_clr_in_init();
    test_midsweep_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
